// File: rtl/int_ctrl.sv
// Interrupt/exception controller feeding NPC.
// Latches, prioritises and sequences traps.
module int_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [2:0]  MASK_RST = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_timer,
  input  logic             exc_illegal,
  input  logic             exc_ecall,
  input  logic             int_ret,
  input  logic             PCWrite,
  input  logic             mask_we,
  input  logic [2:0]       mask_wdata,
  output logic             INT_Signal,
  output logic [2:0]       INT_PEND,
  output logic             EXL_Set,
  output logic [2:0]       INT_CAUSE,
  output logic [2:0]       mask,
  output logic [CNT_W-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [2:0] INT_NONE  = 3'b000;
  localparam logic [2:0] INT_TIMER = 3'b001;
  localparam logic [2:0] INT_ILL   = 3'b010;
  localparam logic [2:0] INT_ECALL = 3'b011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic       pend_ill;
  logic       pend_ecall;
  logic       new_ill;
  logic       new_ecall;
  logic       eff_ill;
  logic       eff_ecall;
  logic       tmr_req;
  logic [2:0] win;
  logic       take_fire;
  logic       ret_fire;

  assign new_ill   = exc_illegal & mask[1];
  assign new_ecall = exc_ecall & mask[2];
  assign eff_ill   = pend_ill | new_ill;
  assign eff_ecall = pend_ecall | new_ecall;
  assign tmr_req   = irq_timer & mask[0];

  assign take_fire = (state == TAKE) & PCWrite;
  assign ret_fire  = (state == HANDLER) & int_ret & PCWrite;

  // Priority pick among eligible sources, same-cycle pulses included.
  always_comb begin
    win = INT_NONE;
    priority case (1'b1)
      eff_ill:   win = INT_ILL;
      eff_ecall: win = INT_ECALL;
      tmr_req:   win = INT_TIMER;
      default:   win = INT_NONE;
    endcase
  end

  // Next-state logic and the redirect strobe.
  always_comb begin
    state_nxt  = state;
    INT_Signal = 1'b0;
    unique case (state)
      IDLE: begin
        if (win != INT_NONE)
          state_nxt = TAKE;
      end
      TAKE: begin
        INT_Signal = PCWrite;
        if (PCWrite)
          state_nxt = HANDLER;
      end
      HANDLER: begin
        if (int_ret && PCWrite)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Trap code: captured on entry to TAKE, cleared when taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      INT_PEND <= INT_NONE;
    else if (state == IDLE && win != INT_NONE)
      INT_PEND <= win;
    else if (take_fire)
      INT_PEND <= INT_NONE;
  end

  // In-handler flag and cause of the serviced trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EXL_Set   <= 1'b0;
      INT_CAUSE <= INT_NONE;
    end else if (take_fire) begin
      EXL_Set   <= 1'b1;
      INT_CAUSE <= INT_PEND;
    end else if (ret_fire) begin
      EXL_Set   <= 1'b0;
    end
  end

  // Saturating count of traps taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trap_cnt <= '0;
    else if (take_fire && trap_cnt != CNT_MAX)
      trap_cnt <= trap_cnt + 1'b1;
  end

  // Enable mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask <= MASK_RST;
    else if (mask_we)
      mask <= mask_wdata;
  end

  // Exception latches; a mask clear or a taken trap wins over a new pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ill   <= 1'b0;
      pend_ecall <= 1'b0;
    end else begin
      if (mask_we && !mask_wdata[1])
        pend_ill <= 1'b0;
      else if (take_fire && INT_PEND == INT_ILL)
        pend_ill <= 1'b0;
      else if (new_ill)
        pend_ill <= 1'b1;

      if (mask_we && !mask_wdata[2])
        pend_ecall <= 1'b0;
      else if (take_fire && INT_PEND == INT_ECALL)
        pend_ecall <= 1'b0;
      else if (new_ecall)
        pend_ecall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl.
// Scoreboard holds expected trap codes.
module tb_int_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq_timer;
  logic          exc_illegal;
  logic          exc_ecall;
  logic          int_ret;
  logic          PCWrite;
  logic          mask_we;
  logic [2:0]    mask_wdata;
  logic          INT_Signal;
  logic [2:0]    INT_PEND;
  logic          EXL_Set;
  logic [2:0]    INT_CAUSE;
  logic [2:0]    mask;
  logic [CW-1:0] trap_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [2:0] sb_q[$];

  int_ctrl #(.CNT_W(CW), .MASK_RST(3'b111)) dut (
    .clk(clk), .rst(rst),
    .irq_timer(irq_timer),
    .exc_illegal(exc_illegal),
    .exc_ecall(exc_ecall),
    .int_ret(int_ret),
    .PCWrite(PCWrite),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .INT_Signal(INT_Signal),
    .INT_PEND(INT_PEND),
    .EXL_Set(EXL_Set),
    .INT_CAUSE(INT_CAUSE),
    .mask(mask),
    .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt < (1 << CW) - 1)
      exp_cnt++;
  endtask

  // Every redirect must match the next expected trap code.
  always @(negedge clk) begin
    if (!rst && INT_Signal) begin
      chk("redir_exl", {31'd0, EXL_Set}, 32'd0);
      if (sb_q.size() == 0)
        chk("spurious_trap", {29'd0, INT_PEND}, 32'd0);
      else
        chk("trap_code", {29'd0, INT_PEND}, {29'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    irq_timer = 1'b0;
    exc_illegal = 1'b0;
    exc_ecall = 1'b0;
    int_ret = 1'b0;
    PCWrite = 1'b1;
    mask_we = 1'b0;
    mask_wdata = 3'b000;
    tick();
    tick();
    chk("rst_sig", {31'd0, INT_Signal}, 32'd0);
    chk("rst_pend", {29'd0, INT_PEND}, 32'd0);
    chk("rst_exl", {31'd0, EXL_Set}, 32'd0);
    chk("rst_cause", {29'd0, INT_CAUSE}, 32'd0);
    chk("rst_mask", {29'd0, mask}, 32'd7);
    chk("rst_cnt", {30'd0, trap_cnt}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // ecall in IDLE: redirect next cycle, handler after.
    exc_ecall = 1'b1;
    sb_q.push_back(3'b011);
    tick();
    exc_ecall = 1'b0;
    chk("t1_sig", {31'd0, INT_Signal}, 32'd1);
    chk("t1_pend", {29'd0, INT_PEND}, 32'd3);
    tick();
    bump();
    chk("t1_exl", {31'd0, EXL_Set}, 32'd1);
    chk("t1_cause", {29'd0, INT_CAUSE}, 32'd3);
    chk("t1_cnt", {30'd0, trap_cnt}, exp_cnt);
    chk("t1_sig_off", {31'd0, INT_Signal}, 32'd0);
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("t1_ret_exl", {31'd0, EXL_Set}, 32'd0);
    chk("t1_ret_cause", {29'd0, INT_CAUSE}, 32'd3);
    tick();

    // Simultaneous illegal + ecall: illegal first.
    exc_illegal = 1'b1;
    exc_ecall = 1'b1;
    sb_q.push_back(3'b010);
    sb_q.push_back(3'b011);
    tick();
    exc_illegal = 1'b0;
    exc_ecall = 1'b0;
    chk("t2_pend_ill", {29'd0, INT_PEND}, 32'd2);
    tick();
    bump();
    chk("t2_cause_ill", {29'd0, INT_CAUSE}, 32'd2);
    chk("t2_cnt", {30'd0, trap_cnt}, exp_cnt);
    repeat (2) begin
      tick();
      chk("t2_blocked", {31'd0, INT_Signal}, 32'd0);
    end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("t2_ret_exl", {31'd0, EXL_Set}, 32'd0);
    chk("t2_ret_sig", {31'd0, INT_Signal}, 32'd0);
    tick();
    chk("t2_sig2", {31'd0, INT_Signal}, 32'd1);
    chk("t2_pend2", {29'd0, INT_PEND}, 32'd3);
    tick();
    bump();
    chk("t2_cause2", {29'd0, INT_CAUSE}, 32'd3);
    chk("t2_cnt2", {30'd0, trap_cnt}, exp_cnt);

    // Timer held in HANDLER, then masked off before return.
    irq_timer = 1'b1;
    repeat (2) begin
      tick();
      chk("t3_hold", {31'd0, INT_Signal}, 32'd0);
    end
    mask_we = 1'b1;
    mask_wdata = 3'b110;
    tick();
    mask_we = 1'b0;
    chk("t3_mask", {29'd0, mask}, 32'd6);
    exc_ecall = 1'b1;
    tick();
    exc_ecall = 1'b0;
    mask_we = 1'b1;
    mask_wdata = 3'b010;
    tick();
    mask_we = 1'b0;
    chk("t3_mask2", {29'd0, mask}, 32'd2);
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("t3_ret_exl", {31'd0, EXL_Set}, 32'd0);
    repeat (3) begin
      tick();
      chk("t3_no_trap", {31'd0, INT_Signal}, 32'd0);
      chk("t3_no_pend", {29'd0, INT_PEND}, 32'd0);
    end
    irq_timer = 1'b0;
    mask_we = 1'b1;
    mask_wdata = 3'b111;
    tick();
    mask_we = 1'b0;
    tick();

    // TAKE stalled by PCWrite=0 for three cycles.
    PCWrite = 1'b0;
    exc_illegal = 1'b1;
    sb_q.push_back(3'b010);
    tick();
    exc_illegal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_sig", {31'd0, INT_Signal}, 32'd0);
      chk("t4_stall_pend", {29'd0, INT_PEND}, 32'd2);
      chk("t4_stall_exl", {31'd0, EXL_Set}, 32'd0);
      if (i < 2) tick();
    end
    PCWrite = 1'b1;
    #1;
    chk("t4_sig", {31'd0, INT_Signal}, 32'd1);
    tick();
    bump();
    chk("t4_exl", {31'd0, EXL_Set}, 32'd1);
    chk("t4_cnt_sat", {30'd0, trap_cnt}, exp_cnt);
    chk("t4_sig_off", {31'd0, INT_Signal}, 32'd0);
    PCWrite = 1'b0;
    int_ret = 1'b1;
    tick();
    chk("t4_ret_stall", {31'd0, EXL_Set}, 32'd1);
    PCWrite = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("t4_ret_exl", {31'd0, EXL_Set}, 32'd0);
    tick();

    // Return pulse in IDLE does nothing.
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("t5_exl", {31'd0, EXL_Set}, 32'd0);
    chk("t5_pend", {29'd0, INT_PEND}, 32'd0);
    chk("t5_cnt", {30'd0, trap_cnt}, exp_cnt);

    // Timer trap, then reset mid-HANDLER with ecall pending.
    irq_timer = 1'b1;
    sb_q.push_back(3'b001);
    tick();
    chk("t6_pend_tmr", {29'd0, INT_PEND}, 32'd1);
    tick();
    irq_timer = 1'b0;
    bump();
    chk("t6_cause", {29'd0, INT_CAUSE}, 32'd1);
    chk("t6_cnt_sat", {30'd0, trap_cnt}, exp_cnt);
    exc_ecall = 1'b1;
    tick();
    exc_ecall = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_exl", {31'd0, EXL_Set}, 32'd0);
    chk("t6_rst_cause", {29'd0, INT_CAUSE}, 32'd0);
    chk("t6_rst_cnt", {30'd0, trap_cnt}, 32'd0);
    chk("t6_rst_mask", {29'd0, mask}, 32'd7);
    chk("t6_rst_pend", {29'd0, INT_PEND}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("t6_no_trap", {31'd0, INT_Signal}, 32'd0);
      chk("t6_no_exl", {31'd0, EXL_Set}, 32'd0);
    end
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
